// File: rtl/dwc_recovery_ctrl_pkg.sv
// Shared FSM state and interrupt-cause types for the DWC recovery controller.
// Types only; no timing or flow-control behaviour lives here.
package dwc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RETRY,
        WAIT,
        IRQ
    } dwc_rec_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE,
        CAUSE_RETRY,
        CAUSE_WDOG
    } dwc_irq_cause_t;

endpackage

// File: rtl/dwc_recovery_ctrl_if.sv
// Comparator verdict, CPU acknowledge and status bundle of the recovery controller.
// Verdict is a held level until dwc_clear; irq_ack and the control outputs are 1-cycle pulses.
interface dwc_recovery_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
);
    logic              cmp_valid;
    logic              cmp_match;
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_b;
    logic              irq_ack;

    logic              dwc_clear;
    logic              retry_req;
    logic              irq;
    logic [1:0]        irq_cause;
    logic [DATA_W-1:0] fault_a;
    logic [DATA_W-1:0] fault_b;
    logic [CNT_W-1:0]  pass_cnt;
    logic [CNT_W-1:0]  err_cnt;
    logic [CNT_W-1:0]  recov_cnt;

    modport master (
        output cmp_valid, cmp_match, data_a, data_b, irq_ack,
        input  dwc_clear, retry_req, irq, irq_cause, fault_a, fault_b,
               pass_cnt, err_cnt, recov_cnt
    );

    modport slave (
        input  cmp_valid, cmp_match, data_a, data_b, irq_ack,
        output dwc_clear, retry_req, irq, irq_cause, fault_a, fault_b,
               pass_cnt, err_cnt, recov_cnt
    );
endinterface

// File: rtl/dwc_recovery_ctrl_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
// Increment visible one cycle after i_inc; no backpressure.
module dwc_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_inc,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
        end else if (i_inc && (r_q != '1)) begin
            r_q <= r_q + W'(1);
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/dwc_recovery_ctrl.sv
// Consumes DWC comparator verdicts: statistics, first-fault capture, bounded retry and IRQ.
// Verdict at edge N -> dwc_clear in N+1 -> retry_req in N+2; verdicts ignored outside IDLE/WAIT.
module dwc_recovery_ctrl
    import dwc_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MAX_RETRY = 3,
    parameter int CNT_W     = 8,
    parameter int WDOG_CYC  = 1024
) (
    input  logic               clk,
    input  logic               reset,
    dwc_recovery_ctrl_if.slave bus
);

    localparam int RC_W = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int WD_W = (WDOG_CYC < 2) ? 1 : $clog2(WDOG_CYC);
    localparam logic [RC_W-1:0] RC_MAX  = RC_W'(MAX_RETRY);
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(WDOG_CYC - 1);

    dwc_rec_state_t    r_state;
    logic              r_pend;
    logic [RC_W-1:0]   r_retry_cnt;
    logic [WD_W-1:0]   r_wdog;
    dwc_irq_cause_t    r_cause;
    logic [DATA_W-1:0] r_fault_a;
    logic [DATA_W-1:0] r_fault_b;
    logic              r_clear;
    logic              r_retry;
    logic              r_irq;

    dwc_rec_state_t    w_next;
    logic              w_pend_nx;
    logic [RC_W-1:0]   w_rc_nx;
    logic [WD_W-1:0]   w_wdog_nx;
    dwc_irq_cause_t    w_cause_nx;
    logic              w_capture;
    logic              w_inc_pass;
    logic              w_inc_err;
    logic              w_inc_recov;

    always_comb begin
        w_next      = r_state;
        w_pend_nx   = r_pend;
        w_rc_nx     = r_retry_cnt;
        w_wdog_nx   = r_wdog;
        w_cause_nx  = r_cause;
        w_capture   = 1'b0;
        w_inc_pass  = 1'b0;
        w_inc_err   = 1'b0;
        w_inc_recov = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.cmp_valid) begin
                    if (bus.cmp_match) begin
                        w_inc_pass = 1'b1;
                        w_pend_nx  = 1'b0;
                        w_next     = CLEAR;
                    end else begin
                        w_inc_err = 1'b1;
                        w_capture = 1'b1;
                        w_rc_nx   = '0;
                        if (MAX_RETRY == 0) begin
                            w_pend_nx  = 1'b0;
                            w_cause_nx = CAUSE_RETRY;
                            w_next     = IRQ;
                        end else begin
                            w_pend_nx = 1'b1;
                            w_next    = CLEAR;
                        end
                    end
                end
            end
            CLEAR: begin
                w_next = r_pend ? RETRY : IDLE;
            end
            RETRY: begin
                w_rc_nx   = r_retry_cnt + RC_W'(1);
                w_wdog_nx = WD_LOAD;
                w_next    = WAIT;
            end
            WAIT: begin
                // A verdict arriving on the expiry cycle takes priority over the timeout.
                if (bus.cmp_valid) begin
                    if (bus.cmp_match) begin
                        w_inc_recov = 1'b1;
                        w_pend_nx   = 1'b0;
                        w_next      = CLEAR;
                    end else begin
                        w_inc_err = 1'b1;
                        if (r_retry_cnt == RC_MAX) begin
                            w_cause_nx = CAUSE_RETRY;
                            w_next     = IRQ;
                        end else begin
                            w_pend_nx = 1'b1;
                            w_next    = CLEAR;
                        end
                    end
                end else if (r_wdog == '0) begin
                    w_cause_nx = CAUSE_WDOG;
                    w_next     = IRQ;
                end else begin
                    w_wdog_nx = r_wdog - WD_W'(1);
                end
            end
            IRQ: begin
                if (bus.irq_ack) begin
                    w_cause_nx = CAUSE_NONE;
                    w_rc_nx    = '0;
                    w_pend_nx  = 1'b0;
                    w_next     = CLEAR;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_pend      <= 1'b0;
            r_retry_cnt <= '0;
            r_wdog      <= '0;
            r_cause     <= CAUSE_NONE;
            r_fault_a   <= '0;
            r_fault_b   <= '0;
            r_clear     <= 1'b0;
            r_retry     <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_pend      <= w_pend_nx;
            r_retry_cnt <= w_rc_nx;
            r_wdog      <= w_wdog_nx;
            r_cause     <= w_cause_nx;
            // Outputs are registered copies of the state being entered.
            r_clear     <= (w_next == CLEAR);
            r_retry     <= (w_next == RETRY);
            r_irq       <= (w_next == IRQ);
            if (w_capture) begin
                r_fault_a <= bus.data_a;
                r_fault_b <= bus.data_b;
            end
        end
    end

    dwc_sat_counter #(.W(CNT_W)) u_pass_cnt (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_inc_pass),
        .o_q   (bus.pass_cnt)
    );

    dwc_sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_inc_err),
        .o_q   (bus.err_cnt)
    );

    dwc_sat_counter #(.W(CNT_W)) u_recov_cnt (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_inc_recov),
        .o_q   (bus.recov_cnt)
    );

    assign bus.dwc_clear = r_clear;
    assign bus.retry_req = r_retry;
    assign bus.irq       = r_irq;
    assign bus.irq_cause = r_cause;
    assign bus.fault_a   = r_fault_a;
    assign bus.fault_b   = r_fault_b;

endmodule

// File: tb/tb_dwc_recovery_ctrl.sv
// Directed bench for dwc_recovery_ctrl: per-cycle vector table plus watchdog, reset and saturation sequences.
module tb_dwc_recovery_ctrl;

    localparam int WD = 1024;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dwc_recovery_ctrl_if #(.DATA_W(32), .CNT_W(8)) bus ();
    dwc_recovery_ctrl_if #(.DATA_W(32), .CNT_W(2)) sbus ();

    dwc_recovery_ctrl #(.DATA_W(32), .MAX_RETRY(3), .CNT_W(8), .WDOG_CYC(WD)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    dwc_recovery_ctrl #(.DATA_W(32), .MAX_RETRY(3), .CNT_W(2), .WDOG_CYC(WD)) u_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (sbus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        v, m;
        logic [31:0] a, b;
        logic        ack;
        logic        clr, rr, irq;
        logic [1:0]  cause;
        logic [7:0]  pass, err, recov;
        logic [31:0] fa, fb;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, m, input logic [31:0] a, b, input logic ack,
                       input logic clr, rr, irq, input logic [1:0] cause,
                       input logic [7:0] pass, err, recov, input logic [31:0] fa, fb);
        vec_t t;
        t.v = v; t.m = m; t.a = a; t.b = b; t.ack = ack;
        t.clr = clr; t.rr = rr; t.irq = irq; t.cause = cause;
        t.pass = pass; t.err = err; t.recov = recov; t.fa = fa; t.fb = fb;
        vecs.push_back(t);
    endtask

    function automatic logic [92:0] obs();
        return {bus.dwc_clear, bus.retry_req, bus.irq, bus.irq_cause,
                bus.pass_cnt, bus.err_cnt, bus.recov_cnt, bus.fault_a, bus.fault_b};
    endfunction

    function automatic logic [92:0] pk(input logic clr, rr, irq, input logic [1:0] cause,
                                       input logic [7:0] pass, err, recov,
                                       input logic [31:0] fa, fb);
        return {clr, rr, irq, cause, pass, err, recov, fa, fb};
    endfunction

    task automatic check(input string name, input logic [92:0] act, input logic [92:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, m, input logic [31:0] a, b, input logic ack);
        bus.cmp_valid = v;
        bus.cmp_match = m;
        bus.data_a    = a;
        bus.data_b    = b;
        bus.irq_ack   = ack;
    endtask

    localparam logic [31:0] F  = 32'hFFFF_FFFF;
    localparam logic [31:0] A1 = 32'h1234_5678;
    localparam logic [31:0] B1 = 32'h1234_5679;
    localparam logic [31:0] DA = 32'h0000_DEAD;
    localparam logic [31:0] DB = 32'h0000_BEEF;
    localparam logic [31:0] C1 = 32'hCAFE_0001;
    localparam logic [31:0] C2 = 32'hCAFE_0002;

    initial begin
        logic saw_irq;

        drive(1'b0, 1'b0, '0, '0, 1'b0);
        sbus.cmp_valid = 1'b0; sbus.cmp_match = 1'b0;
        sbus.data_a = '0; sbus.data_b = '0; sbus.irq_ack = 1'b0;

        //   v  m  a   b   ack | clr rr irq cause pass err recov fa  fb
        add(1, 1, 0,  0,  0,    1, 0, 0, 0, 1, 0, 0, 0,  0);   // match in IDLE
        add(0, 0, 0,  0,  0,    0, 0, 0, 0, 1, 0, 0, 0,  0);
        add(0, 0, 0,  0,  0,    0, 0, 0, 0, 1, 0, 0, 0,  0);
        add(1, 0, F,  0,  0,    1, 0, 0, 0, 1, 1, 0, F,  0);   // mismatch: capture
        add(0, 0, 0,  0,  0,    0, 1, 0, 0, 1, 1, 0, F,  0);   // retry 2 edges after verdict
        add(0, 0, 0,  0,  0,    0, 0, 0, 0, 1, 1, 0, F,  0);
        add(0, 0, 0,  0,  0,    0, 0, 0, 0, 1, 1, 0, F,  0);
        add(1, 1, 0,  0,  0,    1, 0, 0, 0, 1, 1, 1, F,  0);   // recovered in WAIT
        add(0, 0, 0,  0,  0,    0, 0, 0, 0, 1, 1, 1, F,  0);
        add(1, 0, A1, B1, 0,    1, 0, 0, 0, 1, 2, 1, A1, B1);  // new episode
        add(1, 1, 0,  0,  0,    0, 1, 0, 0, 1, 2, 1, A1, B1);  // verdict in CLEAR ignored
        add(1, 0, DA, DB, 0,    0, 0, 0, 0, 1, 2, 1, A1, B1);  // verdict in RETRY ignored
        add(1, 0, DA, DB, 0,    1, 0, 0, 0, 1, 3, 1, A1, B1);  // fail 1, fault regs kept
        add(0, 0, 0,  0,  0,    0, 1, 0, 0, 1, 3, 1, A1, B1);
        add(0, 0, 0,  0,  0,    0, 0, 0, 0, 1, 3, 1, A1, B1);
        add(1, 0, DA, DB, 0,    1, 0, 0, 0, 1, 4, 1, A1, B1);  // fail 2
        add(0, 0, 0,  0,  0,    0, 1, 0, 0, 1, 4, 1, A1, B1);
        add(0, 0, 0,  0,  0,    0, 0, 0, 0, 1, 4, 1, A1, B1);
        add(1, 0, DA, DB, 0,    0, 0, 1, 1, 1, 5, 1, A1, B1);  // fail 3: retries exhausted
        add(1, 0, DA, DB, 0,    0, 0, 1, 1, 1, 5, 1, A1, B1);  // verdict in IRQ ignored
        add(0, 0, 0,  0,  1,    1, 0, 0, 0, 1, 5, 1, A1, B1);  // ack -> CLEAR
        add(0, 0, 0,  0,  0,    0, 0, 0, 0, 1, 5, 1, A1, B1);
        add(0, 0, 0,  0,  1,    0, 0, 0, 0, 1, 5, 1, A1, B1);  // ack outside IRQ ignored
        add(1, 1, 0,  0,  0,    1, 0, 0, 0, 2, 5, 1, A1, B1);
        add(0, 0, 0,  0,  0,    0, 0, 0, 0, 2, 5, 1, A1, B1);

        repeat (2) tick();
        check("reset_state", obs(), '0);
        reset = 1'b1;
        tick();
        check("idle_after_release", obs(), '0);

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].m, vecs[i].a, vecs[i].b, vecs[i].ack);
            tick();
            check($sformatf("row%0d", i), obs(),
                  pk(vecs[i].clr, vecs[i].rr, vecs[i].irq, vecs[i].cause, vecs[i].pass,
                     vecs[i].err, vecs[i].recov, vecs[i].fa, vecs[i].fb));
        end
        drive(1'b0, 1'b0, '0, '0, 1'b0);

        // Watchdog expiry: WAIT lasts WD cycles before IRQ with cause 10.
        drive(1'b1, 1'b0, C1, C2, 1'b0);
        tick();
        check("wd_capture", obs(), pk(1, 0, 0, 0, 2, 6, 1, C1, C2));
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        tick();
        check("wd_retry", obs(), pk(0, 1, 0, 0, 2, 6, 1, C1, C2));
        tick();
        saw_irq = 1'b0;
        repeat (WD - 1) begin
            tick();
            saw_irq = saw_irq | bus.irq;
        end
        check("wd_not_early", 93'(saw_irq), 93'(0));
        tick();
        check("wd_expire", obs(), pk(0, 0, 1, 2, 2, 6, 1, C1, C2));
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        tick();
        check("wd_ack", obs(), pk(1, 0, 0, 0, 2, 6, 1, C1, C2));
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        tick();

        // Verdict on the expiry cycle beats the watchdog.
        drive(1'b1, 1'b0, A1, B1, 1'b0);
        tick();
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        tick();
        tick();
        repeat (WD - 1) tick();
        check("race_still_wait", obs(), pk(0, 0, 0, 0, 2, 7, 1, A1, B1));
        drive(1'b1, 1'b1, '0, '0, 1'b0);
        tick();
        check("race_verdict_wins", obs(), pk(1, 0, 0, 0, 2, 7, 2, A1, B1));
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        tick();
        check("race_idle", obs(), pk(0, 0, 0, 0, 2, 7, 2, A1, B1));

        // Asynchronous reset in WAIT, then a held verdict after release.
        drive(1'b1, 1'b0, C1, C2, 1'b0);
        tick();
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        repeat (4) tick();
        #3 reset = 1'b0;
        #1 check("async_reset", obs(), '0);
        drive(1'b1, 1'b1, '0, '0, 1'b0);
        #2 reset = 1'b1;
        tick();
        check("held_first", obs(), pk(1, 0, 0, 0, 1, 0, 0, 0, 0));
        tick();
        check("held_in_clear", obs(), pk(0, 0, 0, 0, 1, 0, 0, 0, 0));
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        tick();
        check("held_once", obs(), pk(0, 0, 0, 0, 1, 0, 0, 0, 0));

        // 2-bit counter saturation on the second instance.
        for (int k = 1; k <= 5; k++) begin
            sbus.cmp_valid = 1'b1;
            sbus.cmp_match = 1'b1;
            tick();
            sbus.cmp_valid = 1'b0;
            tick();
            if (k == 3) check("sat_at3", 93'(sbus.pass_cnt), 93'(3));
        end
        check("sat_after5", 93'(sbus.pass_cnt), 93'(3));
        check("sat_err_zero", 93'(sbus.err_cnt), 93'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
